// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 frame deserialiser that emits make codes and drops break sequences; build option PS2_PARITY_CHECK_EN enables the odd-parity check
module ps2_scan_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int COUNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyb_clk,
    input  logic       keyb_data,
    output logic [7:0] scan_code,
    output logic       key_ext,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
    state_t               r_state, w_state_nx;
    logic [SYNC_STAGES-1:0] r_kclk_sync, r_kdat_sync;
    logic                 r_kclk_d;
    logic [7:0]           r_shift, w_shift_nx;
    logic [2:0]           r_bit_cnt, w_cnt_nx;
    logic                 r_par_ok, w_par_ok_nx;
    logic [COUNT_W-1:0]   r_wd, w_wd_nx;
    logic                 r_break_pend, r_ext_pend;
    logic [7:0]           r_scan_code;
    logic                 r_key_ext, r_code_valid, r_frame_err;
    logic                 w_kclk, w_kdat, w_fall, w_accept, w_err, w_par_calc;
    assign w_kclk     = r_kclk_sync[SYNC_STAGES-1];
    assign w_kdat     = r_kdat_sync[SYNC_STAGES-1];
    assign w_fall     = r_kclk_d & ~w_kclk;
`ifdef PS2_PARITY_CHECK_EN
    assign w_par_calc = ^{r_shift, w_kdat};
`else
    assign w_par_calc = 1'b1;
`endif
    assign scan_code  = r_scan_code;
    assign key_ext    = r_key_ext;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_state != S_IDLE;
    // synchronise the keyboard lines (idle high) and keep the previous clock level for fall detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kclk_sync <= '1;
            r_kdat_sync <= '1;
            r_kclk_d    <= 1'b1;
        end else begin
            r_kclk_sync <= {r_kclk_sync[SYNC_STAGES-2:0], keyb_clk};
            r_kdat_sync <= {r_kdat_sync[SYNC_STAGES-2:0], keyb_data};
            r_kclk_d    <= w_kclk;
        end
    end
    // frame FSM next state: advances on a keyboard clock fall, watchdog expiry aborts a partial frame
    always_comb begin
        w_state_nx  = r_state;
        w_shift_nx  = r_shift;
        w_cnt_nx    = r_bit_cnt;
        w_par_ok_nx = r_par_ok;
        w_wd_nx     = (r_state == S_IDLE || w_fall) ? '0 : r_wd + COUNT_W'(1);
        w_accept    = 1'b0;
        w_err       = 1'b0;
        if (r_state != S_IDLE && r_wd == COUNT_W'(TIMEOUT_CYCLES - 1)) begin
            w_err      = 1'b1;
            w_state_nx = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = w_kdat ? S_IDLE : S_DATA;
                    w_cnt_nx   = 3'd0;
                end
                S_DATA: begin
                    w_shift_nx = {w_kdat, r_shift[7:1]};
                    w_cnt_nx   = r_bit_cnt + 3'd1;
                    w_state_nx = (r_bit_cnt == 3'd7) ? S_PARITY : S_DATA;
                end
                S_PARITY: begin
                    w_par_ok_nx = w_par_calc;
                    w_state_nx  = S_STOP;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_accept   = w_kdat & r_par_ok;
                    w_err      = ~(w_kdat & r_par_ok);
                end
            endcase
        end
    end
    // frame FSM state and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_ok  <= 1'b0;
            r_wd      <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_bit_cnt <= w_cnt_nx;
            r_par_ok  <= w_par_ok_nx;
            r_wd      <= w_wd_nx;
        end
    end
    // accepted-code handling: E0/F0 prefixes, break consumption and the output pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_code  <= 8'h00;
            r_key_ext    <= 1'b0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_pend <= 1'b0;
            r_ext_pend   <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= w_err;
            if (w_err) begin
                r_break_pend <= 1'b0;
                r_ext_pend   <= 1'b0;
            end else if (w_accept) begin
                if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_break_pend <= 1'b1;
                end else if (r_break_pend) begin
                    r_break_pend <= 1'b0;
                    r_ext_pend   <= 1'b0;
                end else begin
                    r_scan_code  <= r_shift;
                    r_key_ext    <= r_ext_pend;
                    r_code_valid <= 1'b1;
                    r_ext_pend   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: table-driven frame vectors plus timeout, latency and reset sequences
module tb_ps2_scan_receiver;
    localparam int TO = 300;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       keyb_clk = 1'b1;
    logic       keyb_data = 1'b1;
    logic [7:0] scan_code;
    logic       key_ext, code_valid, frame_err, busy;
    int checks = 0, errors = 0;
    int n_valid = 0, n_err = 0;
    time t_fall = 0, t_valid = 0;
    ps2_scan_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .keyb_clk(keyb_clk), .keyb_data(keyb_data),
        .scan_code(scan_code), .key_ext(key_ext), .code_valid(code_valid),
        .frame_err(frame_err), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (code_valid) begin
            n_valid++;
            t_valid = $time;
        end
        if (frame_err) n_err++;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) keyb_data = bits[i];
            repeat (3) @(negedge clk);
            keyb_clk = 1'b0;
            t_fall = $time;
            repeat (4) @(negedge clk);
            keyb_clk = 1'b1;
        end
    endtask
    function automatic logic [10:0] frame(input logic [7:0] code, input logic flip, input logic stop);
        return {stop, (~^code) ^ flip, code, 1'b0};
    endfunction
    typedef struct {
        logic [7:0] code;
        logic       flip;
        logic       stop;
        int         dv;
        int         de;
        logic [7:0] scan;
        logic       ext;
    } vec_t;
    vec_t v[15];
    initial begin
        int bv, be;
        v[0]  = '{8'h16, 0, 1, 1, 0, 8'h16, 0};
        v[1]  = '{8'hF0, 0, 1, 0, 0, 8'h16, 0};
        v[2]  = '{8'h16, 0, 1, 0, 0, 8'h16, 0};
        v[3]  = '{8'h1E, 0, 1, 1, 0, 8'h1E, 0};
        v[4]  = '{8'hE0, 0, 1, 0, 0, 8'h1E, 0};
        v[5]  = '{8'h5A, 0, 1, 1, 0, 8'h5A, 1};
        v[6]  = '{8'h5A, 0, 1, 1, 0, 8'h5A, 0};
        v[7]  = '{8'h55, 0, 0, 0, 1, 8'h5A, 0};
`ifdef PS2_PARITY_CHECK_EN
        v[8]  = '{8'h26, 1, 1, 0, 1, 8'h5A, 0};
`else
        v[8]  = '{8'h26, 1, 1, 1, 0, 8'h26, 0};
`endif
        v[9]  = '{8'hE0, 0, 1, 0, 0, v[8].scan, 0};
        v[10] = '{8'h4E, 0, 0, 0, 1, v[8].scan, 0};
        v[11] = '{8'h4E, 0, 1, 1, 0, 8'h4E, 0};
        v[12] = '{8'hF0, 0, 1, 0, 0, 8'h4E, 0};
        v[13] = '{8'h1C, 0, 0, 0, 1, 8'h4E, 0};
        v[14] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0};
        repeat (3) @(negedge clk);
        chk("reset scan_code", {24'h0, scan_code}, 0);
        chk("reset key_ext", {31'h0, key_ext}, 0);
        chk("reset code_valid", {31'h0, code_valid}, 0);
        chk("reset frame_err", {31'h0, frame_err}, 0);
        chk("reset busy", {31'h0, busy}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            bv = n_valid;
            be = n_err;
            send_bits(frame(v[i].code, v[i].flip, v[i].stop), 11);
            repeat (10) @(negedge clk);
            chk($sformatf("v%0d valid pulses", i), n_valid - bv, v[i].dv);
            chk($sformatf("v%0d err pulses", i), n_err - be, v[i].de);
            chk($sformatf("v%0d scan_code", i), {24'h0, scan_code}, {24'h0, v[i].scan});
            chk($sformatf("v%0d key_ext", i), {31'h0, key_ext}, {31'h0, v[i].ext});
            chk($sformatf("v%0d busy", i), {31'h0, busy}, 0);
            if (i == 0) chk("latency stop fall to code_valid", t_valid - t_fall, 30);
        end
        be = n_err;
        send_bits(11'h7FF, 1);
        repeat (10) @(negedge clk);
        chk("idle high bit err", n_err - be, 0);
        chk("idle high bit busy", {31'h0, busy}, 0);
        be = n_err;
        bv = n_valid;
        send_bits(frame(8'h4E, 0, 1), 4);
        chk("partial busy", {31'h0, busy}, 1);
        repeat (TO + 20) @(negedge clk);
        chk("timeout err pulses", n_err - be, 1);
        chk("timeout busy", {31'h0, busy}, 0);
        chk("timeout no valid", n_valid - bv, 0);
        send_bits(frame(8'h2D, 0, 1), 11);
        repeat (10) @(negedge clk);
        chk("after timeout valid", n_valid - bv, 1);
        chk("after timeout scan", {24'h0, scan_code}, 32'h2D);
        send_bits(frame(8'hE0, 0, 1), 11);
        send_bits(frame(8'h4E, 0, 1), 5);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("mid reset scan_code", {24'h0, scan_code}, 0);
        chk("mid reset busy", {31'h0, busy}, 0);
        chk("mid reset key_ext", {31'h0, key_ext}, 0);
        keyb_clk = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        bv = n_valid;
        send_bits(frame(8'h55, 0, 1), 11);
        repeat (10) @(negedge clk);
        chk("post reset valid", n_valid - bv, 1);
        chk("post reset scan", {24'h0, scan_code}, 32'h55);
        chk("post reset ext cleared", {31'h0, key_ext}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    always @(negedge clk) begin
        if (code_valid && frame_err) begin
            errors++;
            $display("FAIL overlap: code_valid=%0b frame_err=%0b required not both", code_valid, frame_err);
        end
    end
endmodule
